// File: rtl/sad_unit_pkg.sv
// Shared defaults and FSM encoding for the SAD engine and its memories.
package sad_unit_pkg;

    localparam int unsigned DEF_D_WIDTH = 8;
    localparam int unsigned DEF_A_WIDTH = 8;
    localparam int unsigned DEF_N_ELEM  = 256;
    localparam int unsigned SUM_WIDTH   = 32;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInit = 3'd1,
        StRead = 3'd2,
        StAcc  = 3'd3,
        StDone = 3'd4
    } state_e;

endpackage

// File: rtl/sad_unit_if.sv
// Bus between the SAD controller and the two operand memories plus its control/status.
interface sad_unit_if #(
    parameter int unsigned D_WIDTH = sad_unit_pkg::DEF_D_WIDTH,
    parameter int unsigned A_WIDTH = sad_unit_pkg::DEF_A_WIDTH
);
    logic               go;
    logic [A_WIDTH-1:0] a_addr;
    logic [D_WIDTH-1:0] a_data;
    logic [A_WIDTH-1:0] b_addr;
    logic [D_WIDTH-1:0] b_data;
    logic               rw;
    logic               en;
    logic               done;
    logic [31:0]        sad_out;

    modport master (
        input  go, a_data, b_data,
        output a_addr, b_addr, rw, en, done, sad_out
    );

    modport slave (
        output go, a_data, b_data,
        input  a_addr, b_addr, rw, en, done, sad_out
    );
endinterface

// File: rtl/sad_sram.sv
// Single-port synchronous SRAM with registered read data; reset clears only the read register.
module sad_sram import sad_unit_pkg::*; #(
    parameter int unsigned D_WIDTH = DEF_D_WIDTH,
    parameter int unsigned A_WIDTH = DEF_A_WIDTH
) (
    input  logic [D_WIDTH-1:0] Di,
    output logic [D_WIDTH-1:0] Do,
    input  logic [A_WIDTH-1:0] Addr,
    input  logic               RW,
    input  logic               En,
    input  logic               Clk,
    input  logic               Rst
);

    logic [D_WIDTH-1:0] Memory [2**A_WIDTH];
    logic [D_WIDTH-1:0] r_do;

    // Storage has no reset so preloaded contents survive Rst.
    always_ff @(posedge Clk) begin
        if (En && RW) begin
            Memory[Addr] <= Di;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_do <= '0;
        end else if (En && !RW) begin
            r_do <= Memory[Addr];
        end
    end

    assign Do = r_do;

endmodule

// File: rtl/sad_unit.sv
// Sum-of-absolute-differences controller: walks both memories one element per two cycles.
module sad_unit import sad_unit_pkg::*; #(
    parameter int unsigned D_WIDTH = DEF_D_WIDTH,
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned N_ELEM  = DEF_N_ELEM
) (
    input  logic               Go,
    output logic [A_WIDTH-1:0] A_Addr,
    input  logic [D_WIDTH-1:0] A_Data,
    output logic [A_WIDTH-1:0] B_Addr,
    input  logic [D_WIDTH-1:0] B_Data,
    output logic               RW,
    output logic               En,
    output logic               Done,
    output logic [31:0]        SAD_Out,
    input  logic               Clk,
    input  logic               Rst
);

    localparam logic [A_WIDTH:0] LAST_IDX = (A_WIDTH + 1)'(N_ELEM - 1);

    state_e             r_state, w_state_next;
    logic [A_WIDTH:0]   r_i, w_i_next;
    logic [31:0]        r_sum, w_sum_next;
    logic [31:0]        r_sad_out, w_sad_out_next;
    logic [D_WIDTH-1:0] w_diff;
    logic [31:0]        w_abs;

    assign w_diff = (A_Data >= B_Data) ? (A_Data - B_Data) : (B_Data - A_Data);
    assign w_abs  = 32'(w_diff);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state   <= StIdle;
            r_i       <= '0;
            r_sum     <= '0;
            r_sad_out <= '0;
        end else begin
            r_state   <= w_state_next;
            r_i       <= w_i_next;
            r_sum     <= w_sum_next;
            r_sad_out <= w_sad_out_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_i_next       = r_i;
        w_sum_next     = r_sum;
        w_sad_out_next = r_sad_out;
        case (r_state)
            StIdle: begin
                if (Go) w_state_next = StInit;
            end
            StInit: begin
                w_sum_next   = '0;
                w_i_next     = '0;
                w_state_next = StRead;
            end
            StRead: begin
                w_state_next = StAcc;
            end
            // Read data for element r_i is valid here, one cycle after the address was captured.
            StAcc: begin
                w_sum_next = r_sum + w_abs;
                w_i_next   = r_i + 1'b1;
                if (r_i == LAST_IDX) begin
                    w_sad_out_next = r_sum + w_abs;
                    w_state_next   = StDone;
                end else begin
                    w_state_next = StRead;
                end
            end
            StDone: begin
                if (Go) w_state_next = StInit;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign A_Addr  = r_i[A_WIDTH-1:0];
    assign B_Addr  = r_i[A_WIDTH-1:0];
    assign RW      = 1'b0;
    assign En      = (r_state == StRead);
    assign Done    = (r_state == StDone);
    assign SAD_Out = r_sad_out;

endmodule

// File: tb/tb_sad_unit.sv
// Self-checking bench for sad_unit with two sad_sram operand memories.
module tb_sad_unit;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 8;
    localparam int unsigned N   = 256;
    localparam int          LAT = 2 * N + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sad_unit_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

    // Bench-side memory port, muxed in while loading or testing the SRAM alone.
    logic          tb_own = 1'b1;
    logic          tb_en  = 1'b0;
    logic          tb_rw  = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [DW-1:0] tb_da  = '0;
    logic [DW-1:0] tb_db  = '0;

    logic [AW-1:0] w_a_addr, w_b_addr;
    logic          w_rw, w_en;
    assign w_a_addr = tb_own ? tb_addr : bus.a_addr;
    assign w_b_addr = tb_own ? tb_addr : bus.b_addr;
    assign w_rw     = tb_own ? tb_rw : bus.rw;
    assign w_en     = tb_own ? tb_en : bus.en;

    sad_unit #(.D_WIDTH(DW), .A_WIDTH(AW), .N_ELEM(N)) u_dut (
        .Go      (bus.go),
        .A_Addr  (bus.a_addr),
        .A_Data  (bus.a_data),
        .B_Addr  (bus.b_addr),
        .B_Data  (bus.b_data),
        .RW      (bus.rw),
        .En      (bus.en),
        .Done    (bus.done),
        .SAD_Out (bus.sad_out),
        .Clk     (clk),
        .Rst     (rst)
    );

    sad_sram #(.D_WIDTH(DW), .A_WIDTH(AW)) u_mem_a (
        .Di   (tb_da),
        .Do   (bus.a_data),
        .Addr (w_a_addr),
        .RW   (w_rw),
        .En   (w_en),
        .Clk  (clk),
        .Rst  (rst)
    );

    sad_sram #(.D_WIDTH(DW), .A_WIDTH(AW)) u_mem_b (
        .Di   (tb_db),
        .Do   (bus.b_data),
        .Addr (w_b_addr),
        .RW   (w_rw),
        .En   (w_en),
        .Clk  (clk),
        .Rst  (rst)
    );

    int unsigned ma [N];
    int unsigned mb [N];
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        int          kind;
        longint      exp_sum;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint ref_sad();
        longint s = 0;
        for (int k = 0; k < N; k++) begin
            s += (ma[k] > mb[k]) ? longint'(ma[k] - mb[k]) : longint'(mb[k] - ma[k]);
        end
        return s % (64'd1 << 32);
    endfunction

    // 0: A==B random, 1: A=FF B=00, 2: swapped, 3: four +-1 differences, 4: fully random.
    task automatic fill(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                1: begin ma[k] = 255; mb[k] = 0; end
                2: begin ma[k] = 0; mb[k] = 255; end
                4: begin ma[k] = $urandom_range(0, 255); mb[k] = $urandom_range(0, 255); end
                default: begin ma[k] = $urandom_range(0, 255); mb[k] = ma[k]; end
            endcase
        end
        if (kind == 3) begin
            ma[5] = 100;   mb[5] = 101;
            ma[77] = 201;  mb[77] = 200;
            ma[130] = 0;   mb[130] = 1;
            ma[255] = 255; mb[255] = 254;
        end
    endtask

    task automatic load_all();
        tb_own = 1'b1;
        for (int k = 0; k < N; k++) begin
            tb_addr = AW'(k);
            tb_da   = DW'(ma[k]);
            tb_db   = DW'(mb[k]);
            tb_rw   = 1'b1;
            tb_en   = 1'b1;
            @(negedge clk);
        end
        tb_en  = 1'b0;
        tb_rw  = 1'b0;
        tb_own = 1'b0;
    endtask

    task automatic write_pair(input int k, input int unsigned a, input int unsigned b);
        ma[k] = a;
        mb[k] = b;
        tb_own  = 1'b1;
        tb_addr = AW'(k);
        tb_da   = DW'(a);
        tb_db   = DW'(b);
        tb_rw   = 1'b1;
        tb_en   = 1'b1;
        @(negedge clk);
        tb_en  = 1'b0;
        tb_rw  = 1'b0;
        tb_own = 1'b0;
    endtask

    // Pulse Go, count edges (including the sampling edge) until Done, then check the result.
    task automatic run_and_check(input string name, input longint exp, input bit busy_go);
        int edges;
        bus.go = 1'b1;
        @(negedge clk);
        edges  = 1;
        bus.go = 1'b0;
        check({name, "_done_low"}, longint'(bus.done), 0);
        while (bus.done !== 1'b1 && edges < 3000) begin
            bus.go = busy_go && (edges == 50 || edges == 301);
            @(negedge clk);
            edges++;
        end
        bus.go = 1'b0;
        check({name, "_latency"}, edges, LAT);
        check({name, "_sad"}, longint'(bus.sad_out), exp);
        repeat (3) @(negedge clk);
        check({name, "_done_held"}, longint'(bus.done), 1);
        check({name, "_sad_held"}, longint'(bus.sad_out), exp);
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{name: "equal",   kind: 0, exp_sum: 0};
        vecs[1] = '{name: "ff_00",   kind: 1, exp_sum: 65280};
        vecs[2] = '{name: "00_ff",   kind: 2, exp_sum: 65280};
        vecs[3] = '{name: "four_d1", kind: 3, exp_sum: 4};

        bus.go = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_done", longint'(bus.done), 0);
        check("rst_sad", longint'(bus.sad_out), 0);
        check("rst_en", longint'(bus.en), 0);
        check("rst_rw", longint'(bus.rw), 0);
        check("rst_addr", longint'(bus.a_addr), 0);

        // SRAM alone: write, registered read, hold with En=0, reset clears only Do.
        tb_own = 1'b1;
        tb_addr = 3; tb_da = 8'h5A; tb_rw = 1'b1; tb_en = 1'b1;
        @(negedge clk);
        tb_rw = 1'b0;
        @(negedge clk);
        check("sram_read", longint'(bus.a_data), 'h5A);
        tb_en = 1'b0; tb_addr = 4;
        @(negedge clk);
        check("sram_hold", longint'(bus.a_data), 'h5A);
        rst = 1'b1;
        #1;
        check("sram_rst_do", longint'(bus.a_data), 0);
        @(negedge clk);
        rst = 1'b0;
        tb_addr = 3; tb_en = 1'b1;
        @(negedge clk);
        check("sram_keep", longint'(bus.a_data), 'h5A);
        tb_en  = 1'b0;
        tb_own = 1'b0;

        foreach (vecs[v]) begin
            fill(vecs[v].kind);
            load_all();
            run_and_check(vecs[v].name, vecs[v].exp_sum, 1'b0);
        end

        // Reset in the middle of a run, with a nonzero result already latched.
        fill(4);
        load_all();
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_done", longint'(bus.done), 0);
        check("midrst_sad", longint'(bus.sad_out), 0);
        check("midrst_en", longint'(bus.en), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_and_check("after_rst", ref_sad(), 1'b0);

        // Edit memory after Done and restart; stray Go pulses while busy.
        write_pair(10, 0, 200);
        write_pair(11, 250, 3);
        check("edit_done_still", longint'(bus.done), 1);
        run_and_check("edit_rerun", ref_sad(), 1'b1);

        for (int r = 0; r < 5; r++) begin
            fill(4);
            load_all();
            run_and_check($sformatf("rand%0d", r), ref_sad(), r[0]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
